// File: rtl/rv_enc_pkg.sv
// Shared constants for the RV32I instruction encoder.
//   - opcode constants for the supported formats
//   - request class coding (same coding as the decoder's ALUOP field)
//   - encoder FSM state type
package rv_enc_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [1:0] CLS_BAD = 2'b00;
    localparam logic [1:0] CLS_LUI = 2'b01;
    localparam logic [1:0] CLS_R   = 2'b10;
    localparam logic [1:0] CLS_I   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: instruction fields + class in, 32-bit word out.
// Ports:
//   cls_i              request class (CLS_R / CLS_I / CLS_LUI / CLS_BAD)
//   rd_i, rs1_i, rs2_i register fields
//   funct3_i, funct7_i function fields
//   imm_i              I-type uses [11:0], LUI uses [19:0]
//   word_o             packed instruction (zero for an invalid class)
//   valid_o            class is one of the supported formats
module instr_pack
    import rv_enc_pkg::*;
(
    input  logic [1:0]  cls_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [19:0] imm_i,
    output logic [31:0] word_o,
    output logic        valid_o
);

    always_comb begin
        word_o  = 32'h0;
        valid_o = 1'b1;
        case (cls_i)
            CLS_R:   word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            CLS_I:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
            CLS_LUI: word_o = {imm_i, rd_i, OP_LUI};
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Field-level instruction requests -> RV32I words written sequentially into
// instruction memory through a one-entry output register.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      pulse: clear address/count/err, begin session
//   in_valid/in_ready          request handshake
//   in_class..in_imm, in_last  request fields, final-request marker
//   imem_we/imem_ready         write handshake; imem_addr/imem_wdata payload
//   busy, done, err            status (err sticky per session)
//   word_count                 words written this session
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [19:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              stop_q, stop_d;   // last/full word accepted
    logic              fin_q, fin_d;     // pending word ends the session

    logic [31:0]       pk_word;
    logic              pk_valid;
    logic              accept, wr_done, final_word;
    logic [ADDR_W-1:0] slot;

    instr_pack u_pack (
        .cls_i    (in_class),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .funct3_i (in_funct3),
        .funct7_i (in_funct7),
        .imm_i    (in_imm),
        .word_o   (pk_word),
        .valid_o  (pk_valid)
    );

    // start wins over a same-cycle request, so it is not handshaken.
    assign in_ready = (state_q == RUN) & ~start & ~stop_q & (~we_q | imem_ready);
    assign accept   = in_valid & in_ready;
    assign wr_done  = we_q & imem_ready;

    // Address the accepted word will land at: one past a word that is
    // completing this cycle, otherwise the current address.
    assign slot       = addr_q + ADDR_W'(we_q);
    assign final_word = in_last | (pk_valid & (slot == LAST_ADDR));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        done_d  = done_q;
        stop_d  = stop_q;
        fin_d   = fin_q;
        if (start) begin
            state_d = RUN;
            addr_d  = '0;
            cnt_d   = '0;
            we_d    = 1'b0;
            err_d   = 1'b0;
            done_d  = 1'b0;
            stop_d  = 1'b0;
            fin_d   = 1'b0;
        end else if (state_q == RUN) begin
            if (wr_done) begin
                cnt_d = cnt_q + 1'b1;
                we_d  = 1'b0;
                // Saturate at the top word: the address never wraps.
                if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
                if (fin_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    fin_d   = 1'b0;
                end
            end
            if (accept) begin
                stop_d = final_word;
                if (pk_valid) begin
                    we_d    = 1'b1;
                    wdata_d = pk_word;
                    fin_d   = final_word;
                end else begin
                    err_d = 1'b1;
                    // Invalid last request ends the session without a write.
                    if (in_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            stop_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            done_q  <= done_d;
            stop_q  <= stop_d;
            fin_q   <= fin_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int AW = 4;
    localparam int MD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_class = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [19:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_ready = 1'b1;
    logic          busy, done, err;
    logic [AW:0]   word_count;

    instr_encoder #(.ADDR_W(AW), .MEM_DEPTH(MD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy),
        .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t q[$];
    int  total = 0;
    int  bad = 0;
    int  nwr = 0;
    int  cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compares every completed memory write against the queue.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && imem_we && imem_ready) begin
            wr_t e;
            nwr++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", imem_addr, imem_wdata);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.a));
                chk("wr_data", imem_wdata, e.d);
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input logic [1:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [19:0] imm, input logic last);
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
    endtask

    // Issue one request; returns just after the accepting edge.
    task automatic send(input logic [1:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [19:0] imm, input logic last,
                        input logic push, input logic [AW-1:0] ea, input logic [31:0] ed);
        int n = 0;
        @(negedge clk);
        drive(c, rd, rs1, rs2, f3, f7, imm, last);
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end else begin
            if (push) q.push_back('{a: ea, d: ed});
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int c0;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", 32'(word_count), 0);
        rst_n = 1'b1;

        // single add x3,x1,x2
        do_start();
        #1 chk("t1_busy", 32'(busy), 1);
        send(2'b10, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'd0, 1'b1, 1'b1, 0, 32'h002081B3);
        #1;
        chk("t1_we", 32'(imem_we), 1);
        chk("t1_addr", 32'(imem_addr), 0);
        chk("t1_wdata", imem_wdata, 32'h002081B3);
        idle();
        repeat (2) @(negedge clk);
        chk("t1_done", 32'(done), 1);
        chk("t1_count", 32'(word_count), 1);

        // back-to-back sub / addi / lui
        do_start();
        chk("t2_done_clr", 32'(done), 0);
        send(2'b10, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 20'd0, 1'b0, 1'b1, 0, 32'h403100B3);
        c0 = cyc;
        send(2'b11, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 20'h00FFF, 1'b0, 1'b1, 1, 32'hFFF00293);
        send(2'b01, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 20'h12345, 1'b1, 1'b1, 2, 32'h123453B7);
        chk("t2_b2b_cycles", 32'(cyc - c0), 2);
        idle();
        repeat (2) @(negedge clk);
        chk("t2_done", 32'(done), 1);
        chk("t2_count", 32'(word_count), 3);
        chk("t2_busy", 32'(busy), 0);
        chk("t2_err", 32'(err), 0);

        // backpressure: stall 3 cycles with a second request waiting
        imem_ready = 1'b0;
        do_start();
        send(2'b10, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'd0, 1'b0, 1'b1, 0, 32'h002081B3);
        c0 = nwr;
        @(negedge clk);
        drive(2'b10, 5'd4, 5'd5, 5'd6, 3'd7, 7'd0, 20'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_in_ready", 32'(in_ready), 0);
            chk("t3_we", 32'(imem_we), 1);
            chk("t3_addr", 32'(imem_addr), 0);
            chk("t3_wdata", imem_wdata, 32'h002081B3);
            @(negedge clk);
        end
        chk("t3_no_write", 32'(nwr - c0), 0);
        imem_ready = 1'b1;
        q.push_back('{a: 1, d: 32'h0062F233});
        #1 chk("t3_ready_up", 32'(in_ready), 1);
        @(posedge clk);
        idle();
        repeat (2) @(negedge clk);
        chk("t3_writes", 32'(nwr - c0), 2);
        chk("t3_count", 32'(word_count), 2);

        // invalid class between two R-types
        do_start();
        send(2'b10, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'd0, 1'b0, 1'b1, 0, 32'h002081B3);
        send(2'b00, 5'd9, 5'd9, 5'd9, 3'd0, 7'd0, 20'd0, 1'b0, 1'b0, 0, 32'h0);
        send(2'b10, 5'd4, 5'd5, 5'd6, 3'd7, 7'd0, 20'd0, 1'b1, 1'b1, 1, 32'h0062F233);
        idle();
        repeat (2) @(negedge clk);
        chk("t4_err", 32'(err), 1);
        chk("t4_count", 32'(word_count), 2);
        chk("t4_done", 32'(done), 1);

        // fill all MEM_DEPTH words without in_last
        do_start();
        chk("t5_err_clr", 32'(err), 0);
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'd1, 1'b0, 1'b1, 0, 32'h00100093);
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'd2, 1'b0, 1'b1, 1, 32'h00200093);
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'd3, 1'b0, 1'b1, 2, 32'h00300093);
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'd4, 1'b0, 1'b1, 3, 32'h00400093);
        @(negedge clk);
        drive(2'b11, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 20'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t5_full_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        chk("t5_done", 32'(done), 1);
        chk("t5_count", 32'(word_count), 4);
        chk("t5_addr_nowrap", 32'(imem_addr), 3);
        in_valid = 1'b0;

        // start while a write is pending and stalled
        do_start();
        send(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 20'd0, 1'b0, 1'b0, 0, 32'h0);
        imem_ready = 1'b0;
        send(2'b10, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'd0, 1'b0, 1'b0, 0, 32'h0);
        #1;
        chk("t6_err_set", 32'(err), 1);
        chk("t6_pending", 32'(imem_we), 1);
        do_start();
        #1;
        chk("t6_we_drop", 32'(imem_we), 0);
        chk("t6_addr", 32'(imem_addr), 0);
        chk("t6_err_clr", 32'(err), 0);
        chk("t6_done_clr", 32'(done), 0);
        imem_ready = 1'b1;
        send(2'b10, 5'd8, 5'd9, 5'd10, 3'd4, 7'd0, 20'd0, 1'b1, 1'b1, 0, 32'h00A4C433);
        idle();
        repeat (2) @(negedge clk);
        chk("t6_done", 32'(done), 1);
        chk("t6_count", 32'(word_count), 1);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the opcode control decoder. It accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit RV32I words (R-type, I-type ALU, LUI). It writes the words sequentially into instruction memory through a one-entry output register with backpressure. Used by the test/boot path to load programs that the core's control decoder later consumes.

Parameters:
ADDR_W, 8, word-address width of instruction memory
MEM_DEPTH, 256, number of writable words; must be 1 to 2**ADDR_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: clear address/count/err, begin session
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready
in_class  input  2  10 R-type, 11 I-type ALU, 01 LUI, 00 invalid (matches ALUOP coding)
in_rd  input  5  destination register
in_rs1  input  5  source 1 (ignored for LUI)
in_rs2  input  5  source 2 (R-type only)
in_funct3  input  3  funct3 (R/I)
in_funct7  input  7  funct7 (R only)
in_imm  input  20  I-type uses [11:0]; LUI uses [19:0]
in_last  input  1  final instruction of session
imem_we  output  1  write request valid
imem_addr  output  ADDR_W  word address
imem_wdata  output  32  packed instruction
imem_ready  input  1  memory accepts write when imem_we & imem_ready
busy  output  1  state is RUN
done  output  1  session complete, held until next start
err  output  1  sticky: invalid class seen this session
word_count  output  ADDR_W+1  words written this session

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready, imem_we, busy, done, err 0; imem_addr, imem_wdata, word_count 0.
- Packing: R = {funct7, rs2, rs1, funct3, rd, 0110011}; I = {imm[11:0], rs1, funct3, rd, 0010011}; LUI = {imm[19:0], rd, 0110111}. Caller supplies shift-immediate upper bits in imm[11:5].
- FSM IDLE -> RUN on start. RUN -> DONE after the write completes for a word that had in_last, or that filled address MEM_DEPTH-1. DONE -> RUN on start.
- start has priority in any state. Next cycle: addr=0, word_count=0, err=0, done=0, pending output dropped (imem_we=0), state RUN.
- IDLE/DONE: in_ready=0, imem_we=0.
- RUN: in_ready = !stop & (!imem_we | imem_ready). stop is set once the last/full word has been accepted.
- Latency: request accepted in cycle N gives imem_we=1 with addr/wdata in cycle N+1. addr/wdata stay stable until imem_ready. Throughput is 1 word/cycle when imem_ready stays high.
- Write completion (imem_we & imem_ready): imem_addr increments, word_count increments. imem_we clears unless a new request is accepted the same cycle.
- Invalid class (00) accepted: no write, address unchanged, err set. It still counts for in_last, so an invalid last request goes to DONE without a write.
- Full: after the word at MEM_DEPTH-1 is accepted, in_ready=0. The address never wraps.
- Reset mid-write: write is abandoned, no partial state survives.

Decomposition:
- Shared package rv_enc_pkg holds:
  - opcode constants: OP_R 0110011, OP_I 0010011, OP_LUI 0110111
  - class constants: CLS_R, CLS_I, CLS_LUI, CLS_BAD
  - state enum: IDLE, RUN, DONE
- One combinational sub-module, instr_pack: fields + class in, 32-bit word + valid-class flag out. It is reusable by the bench's reference model.

Test Plan:
- start, R class rd=3 rs1=1 rs2=2 f3=0 f7=0 (add), imem_ready=1 -> cycle after accept: imem_we=1, addr 0, wdata 0x002081B3.
- Back-to-back: sub x1,x2,x3 (f7=0x20), addi x5,x0,-1 (imm 0xFFF), lui x7,0x12345 with in_last -> writes 0x403100B3@0, 0xFFF00293@1, 0x123453B7@2 on consecutive cycles; then done=1, word_count=3, busy=0.
- imem_ready low 3 cycles with a pending write -> addr/wdata stable, in_ready=0, no second accept; one write completes when ready rises.
- Class 00 between two valid R-type requests -> err=1, only 2 writes at addr 0,1, word_count=2.
- MEM_DEPTH=4, 5 requests without in_last -> 4 writes at addr 0..3, done=1, 5th request never accepted (in_ready=0).
- start asserted while a write is pending and imem_ready=0 -> imem_we=0 next cycle, addr=0, err/done cleared; next request writes at addr 0.
